link_tx: RTL and testbench



---
 rtl/link_tx.sv | 104 ++++++++++
 tb/tb_link_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_tx.sv
// Inter-node transmit stage: elastic FIFO behind the crossbar mux, credit-based
// forwarding onto the link, early backpressure and sticky error flags.
module link_tx #(
    parameter int DataWidth   = 256,
    parameter int FIFODepth   = 8,
    parameter int SkidSlots   = 3,
    parameter int CreditInit  = 128,
    parameter int CreditWidth = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DataWidth-1:0]   in,
    output logic                   out_stall,
    input  logic                   credit_return,
    output logic [DataWidth-1:0]   link_out,
    output logic [CreditWidth-1:0] credit_count,
    output logic                   overflow_err,
    output logic                   credit_err
);

    localparam int PtrW = $clog2(FIFODepth);
    localparam int CntW = PtrW + 1;

    logic [DataWidth-1:0]   mem [FIFODepth];
    logic [PtrW-1:0]        rd_ptr;
    logic [PtrW-1:0]        wr_ptr;
    logic [CntW-1:0]        count;
    logic [CntW-1:0]        count_next;
    logic [CreditWidth-1:0] credit_next;
    logic                   in_valid;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   ovf_set;
    logic                   cerr_set;
    logic                   stall_next;

    always_comb begin
        in_valid    = in[DataWidth-1];
        full        = (count == CntW'(FIFODepth));
        // Pop looks only at stored entries, so a packet always sits in the FIFO for a cycle.
        pop         = (count != '0) && (credit_count != '0);
        push        = in_valid && (!full || pop);
        ovf_set     = in_valid && !push;

        count_next  = count;
        case ({push, pop})
            2'b10:   count_next = count + CntW'(1);
            2'b01:   count_next = count - CntW'(1);
            default: count_next = count;
        endcase

        credit_next = credit_count;
        cerr_set    = 1'b0;
        if (pop && !credit_return) begin
            credit_next = credit_count - CreditWidth'(1);
        end else if (!pop && credit_return) begin
            if (credit_count == CreditWidth'(CreditInit)) begin
                cerr_set = 1'b1;
            end else begin
                credit_next = credit_count + CreditWidth'(1);
            end
        end

        stall_next  = (count_next >= CntW'(FIFODepth - SkidSlots));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            credit_count <= CreditWidth'(CreditInit);
            link_out     <= '0;
            out_stall    <= 1'b0;
            overflow_err <= 1'b0;
            credit_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count        <= count_next;
            credit_count <= credit_next;
            link_out     <= pop ? mem[rd_ptr] : '0;
            out_stall    <= stall_next;
            if (ovf_set) begin
                overflow_err <= 1'b1;
            end
            if (cerr_set) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_link_tx.sv
// Scoreboard bench for link_tx: two instances (CreditInit 128 and 2) with
// per-instance expected-packet queues checked by independent monitors.
module tb_link_tx;

    localparam int DW = 256;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_a, in_b;
    logic          ret_a, ret_b;
    logic [DW-1:0] link_a, link_b;
    logic          stall_a, stall_b;
    logic [CW-1:0] cc_a, cc_b;
    logic          ovf_a, ovf_b;
    logic          cerr_a, cerr_b;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];

    always #5 clk = ~clk;

    link_tx #(.DataWidth(DW), .FIFODepth(8), .SkidSlots(3), .CreditInit(128), .CreditWidth(CW)) u_a (
        .clk(clk), .rst(rst), .in(in_a), .out_stall(stall_a), .credit_return(ret_a),
        .link_out(link_a), .credit_count(cc_a), .overflow_err(ovf_a), .credit_err(cerr_a)
    );

    link_tx #(.DataWidth(DW), .FIFODepth(8), .SkidSlots(3), .CreditInit(2), .CreditWidth(CW)) u_b (
        .clk(clk), .rst(rst), .in(in_b), .out_stall(stall_b), .credit_return(ret_b),
        .link_out(link_b), .credit_count(cc_b), .overflow_err(ovf_b), .credit_err(cerr_b)
    );

    function automatic logic [DW-1:0] mk(input int tag);
        logic [DW-1:0] p;
        p          = '0;
        p[DW-1]    = 1'b1;
        p[31:0]    = tag;
        p[159:128] = ~tag;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every non-idle link word must be the oldest expected packet.
    always @(negedge clk) begin
        if (!rst && link_a !== '0) begin
            n_vec++;
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL link_a unexpected: got %h expected nothing", link_a);
            end else begin
                logic [DW-1:0] e;
                e = q_a.pop_front();
                if (link_a !== e) begin
                    n_err++;
                    $display("FAIL link_a order: got %h expected %h", link_a, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && link_b !== '0) begin
            n_vec++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL link_b unexpected: got %h expected nothing", link_b);
            end else begin
                logic [DW-1:0] e;
                e = q_b.pop_front();
                if (link_b !== e) begin
                    n_err++;
                    $display("FAIL link_b order: got %h expected %h", link_b, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        in_a  = '0;
        in_b  = '0;
        ret_a = 1'b0;
        ret_b = 1'b0;
        tick();
        tick();
        chk("rst cc_a", 64'(cc_a), 64'd128);
        chk("rst cc_b", 64'(cc_b), 64'd2);
        chk("rst stall_a", 64'(stall_a), 64'd0);
        chk_pkt("rst link_a", link_a, '0);
        chk("rst ovf_a", 64'(ovf_a), 64'd0);
        chk("rst cerr_a", 64'(cerr_a), 64'd0);
        rst = 1'b0;

        // Four back-to-back packets: 2-cycle latency, credits 128 -> 124.
        for (int i = 1; i <= 4; i++) begin
            in_a = mk(i);
            q_a.push_back(mk(i));
            tick();
            chk("s1 stall_a", 64'(stall_a), 64'd0);
            if (i == 2) chk_pkt("s1 latency", link_a, mk(1));
        end
        in_a = '0;
        tick();
        chk_pkt("s1 last", link_a, mk(4));
        chk("s1 cc_a", 64'(cc_a), 64'd124);
        tick();
        chk_pkt("s1 idle", link_a, '0);

        // Credit return at CreditInit: with a concurrent pop is legal, without one is an error.
        ret_a = 1'b1;
        repeat (4) tick();
        ret_a = 1'b0;
        chk("s4 refill", 64'(cc_a), 64'd128);
        in_a = mk(32'h50);
        q_a.push_back(mk(32'h50));
        tick();
        in_a  = '0;
        ret_a = 1'b1;
        tick();
        ret_a = 1'b0;
        chk("s4 pop+ret cc", 64'(cc_a), 64'd128);
        chk("s4 pop+ret cerr", 64'(cerr_a), 64'd0);
        ret_a = 1'b1;
        tick();
        ret_a = 1'b0;
        chk("s4 ret cc", 64'(cc_a), 64'd128);
        chk("s4 ret cerr", 64'(cerr_a), 64'd1);

        // CreditInit 2: five packets, two go out, three wait for credits.
        for (int i = 1; i <= 5; i++) begin
            in_b = mk(32'h20 + i);
            q_b.push_back(mk(32'h20 + i));
            tick();
        end
        in_b = '0;
        chk("s2 cc_b", 64'(cc_b), 64'd0);
        chk_pkt("s2 link idle", link_b, '0);
        chk("s2 stall_b", 64'(stall_b), 64'd0);
        tick();
        chk_pkt("s2 held", link_b, '0);
        ret_b = 1'b1;
        tick();
        ret_b = 1'b0;
        chk("s2 cc after ret", 64'(cc_b), 64'd1);
        chk_pkt("s2 no pop yet", link_b, '0);
        tick();
        chk_pkt("s2 pkt3", link_b, mk(32'h23));
        chk("s2 cc spent", 64'(cc_b), 64'd0);
        tick();
        chk_pkt("s2 one only", link_b, '0);
        ret_b = 1'b1;
        tick();
        tick();
        ret_b = 1'b0;
        tick();
        tick();
        chk("s2 drained cc", 64'(cc_b), 64'd0);

        // Zero credits: fill to 8, stall from the 5th push on.
        for (int i = 1; i <= 8; i++) begin
            in_b = mk(32'h30 + i);
            q_b.push_back(mk(32'h30 + i));
            tick();
            chk("s3 stall_b", 64'(stall_b), (i >= 5) ? 64'd1 : 64'd0);
        end
        in_b = '0;
        chk("s3 ovf before", 64'(ovf_b), 64'd0);

        // Full FIFO: credit returned, then a push in the pop cycle is accepted.
        ret_b = 1'b1;
        tick();
        ret_b = 1'b0;
        in_b  = mk(32'h39);
        q_b.push_back(mk(32'h39));
        tick();
        in_b = '0;
        chk_pkt("s5 pop head", link_b, mk(32'h31));
        chk("s5 stall full", 64'(stall_b), 64'd1);
        chk("s5 no drop", 64'(ovf_b), 64'd0);
        chk("s5 cc_b", 64'(cc_b), 64'd0);

        // Full with no credits: the packet is dropped.
        in_b = mk(32'h3A);
        tick();
        in_b = '0;
        chk("s3 ovf set", 64'(ovf_b), 64'd1);
        chk("s3 stall still", 64'(stall_b), 64'd1);
        ret_b = 1'b1;
        repeat (8) tick();
        ret_b = 1'b0;
        repeat (3) tick();
        chk("s3 drain cc", 64'(cc_b), 64'd0);
        chk("s3 drain stall", 64'(stall_b), 64'd0);
        chk("s3 ovf sticky", 64'(ovf_b), 64'd1);

        // Spend all 128 credits, buffer 6 more, then reset between edges.
        for (int i = 0; i < 128; i++) begin
            in_a = mk(32'h100 + i);
            q_a.push_back(mk(32'h100 + i));
            tick();
        end
        in_a = '0;
        tick();
        chk("s6 cc zero", 64'(cc_a), 64'd0);
        for (int i = 0; i < 6; i++) begin
            in_a = mk(32'h200 + i);
            tick();
        end
        in_a = '0;
        chk("s6 stall buffered", 64'(stall_a), 64'd1);
        #3;
        rst = 1'b1;
        q_a.delete();
        #1;
        chk("s6 rst stall", 64'(stall_a), 64'd0);
        chk("s6 rst cc", 64'(cc_a), 64'd128);
        chk("s6 rst cerr", 64'(cerr_a), 64'd0);
        chk_pkt("s6 rst link", link_a, '0);
        tick();
        rst = 1'b0;
        in_a = mk(32'h300);
        q_a.push_back(mk(32'h300));
        tick();
        in_a = '0;
        chk("s6 cc before pop", 64'(cc_a), 64'd128);
        tick();
        chk_pkt("s6 first after rst", link_a, mk(32'h300));
        chk("s6 cc after pop", 64'(cc_a), 64'd127);
        tick();
        tick();
        chk("end q_a empty", 64'(q_a.size()), 64'd0);
        chk("end q_b empty", 64'(q_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
